// File: rtl/rpsc_rf_sequencer.sv
// RPSC RF permit sequencer: latches FF1..FF6 trips, debounces interlocks and drives active-low permit/reduce.
// Define RPSC_FIRST_FAULT_EN to build first-fault capture; otherwise first_fault is tied to zero.
module rpsc_rf_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [5:0]  HARD_MASK     = 6'b111010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] trip,
  input  logic       not_g1_ok,
  input  logic       not_g2_ok,
  input  logic       not_dr_amp_ok,
  input  logic       not_ca_on,
  input  logic       rf_request,
  input  logic       fault_reset,
  output logic [5:0] fault_q,
  output logic       not_alarm,
  output logic       not_rf_perm,
  output logic       not_rf_red,
  output logic [2:0] state,
  output logic [2:0] first_fault
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_PERMIT  = 3'd2;
  localparam logic [2:0] ST_REDUCED = 3'd3;
  localparam logic [2:0] ST_TRIPPED = 3'd4;

  logic [5:0]    fault_d;
  logic [5:0]    fault_any;
  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          not_rf_perm_q;
  logic          not_rf_perm_d;
  logic          not_rf_red_q;
  logic          not_rf_red_d;
  logic          not_alarm_q;
  logic          not_alarm_d;
  logic          perm_ok;
  logic          full_ok;
  logic          soft_fault;
  logic          hard;
  logic          hard_trip_clear;

  // Trips seen this cycle count alongside latched bits so a fault acts on the same edge it is sampled.
  always_comb begin
    fault_any       = fault_q | trip;
    fault_d         = trip | (fault_q & ~{6{fault_reset}});
    hard            = |(fault_any & HARD_MASK);
    soft_fault      = |(fault_any & ~HARD_MASK);
    hard_trip_clear = ~|(trip & HARD_MASK);
    perm_ok         = ~not_g2_ok & ~not_dr_amp_ok;
    full_ok         = ~not_g1_ok & ~not_dr_amp_ok & ~not_ca_on & ~soft_fault;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (hard) begin
          state_d = ST_TRIPPED;
        end else if (rf_request && perm_ok) begin
          state_d = ST_ARM;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_ARM: begin
        if (hard) begin
          state_d = ST_TRIPPED;
          cnt_d   = '0;
        end else if (!perm_ok || !rf_request) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          if (full_ok) begin
            state_d = ST_PERMIT;
          end else begin
            state_d = ST_REDUCED;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PERMIT: begin
        if (hard) begin
          state_d = ST_TRIPPED;
          cnt_d   = '0;
        end else if (!perm_ok || !rf_request) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (!full_ok) begin
          state_d = ST_REDUCED;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_REDUCED: begin
        // Any loss of full conditions restarts the settle window before full power returns.
        if (hard) begin
          state_d = ST_TRIPPED;
          cnt_d   = '0;
        end else if (!perm_ok || !rf_request) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (!full_ok) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_PERMIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_TRIPPED: begin
        if (fault_reset && hard_trip_clear && !rf_request) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    not_rf_perm_d = ~((state_d == ST_PERMIT) || (state_d == ST_REDUCED));
    not_rf_red_d  = ~(state_d == ST_REDUCED);
    not_alarm_d   = ~|fault_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q       <= '0;
      state_q       <= ST_OFF;
      cnt_q         <= '0;
      not_rf_perm_q <= 1'b1;
      not_rf_red_q  <= 1'b1;
      not_alarm_q   <= 1'b1;
    end else begin
      fault_q       <= fault_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      not_rf_perm_q <= not_rf_perm_d;
      not_rf_red_q  <= not_rf_red_d;
      not_alarm_q   <= not_alarm_d;
    end
  end

`ifdef RPSC_FIRST_FAULT_EN
  logic [2:0] first_fault_q;
  logic [2:0] first_fault_d;

  // Descending scan so the lowest set index is the last write and wins.
  always_comb begin
    first_fault_d = first_fault_q;
    if (fault_d == '0) begin
      first_fault_d = 3'd0;
    end else if (fault_q == '0) begin
      for (int i = 5; i >= 0; i--) begin
        if (fault_d[i]) begin
          first_fault_d = 3'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first_fault_q <= 3'd0;
    end else begin
      first_fault_q <= first_fault_d;
    end
  end

  assign first_fault = first_fault_q;
`else
  assign first_fault = 3'd0;
`endif

  assign state       = state_q;
  assign not_rf_perm = not_rf_perm_q;
  assign not_rf_red  = not_rf_red_q;
  assign not_alarm   = not_alarm_q;

endmodule
